// File: rtl/bounce_gen.sv
// bounce_gen: mechanical-switch emulator; turns a clean level request into a
// pseudo-random bounce burst followed by a stable, settled level.
module bounce_gen #(
    parameter int          BOUNCE_CYCLES = 16,
    parameter int          NBOUNCES      = 6,
    parameter int          SETTLE_CYCLES = 64,
    parameter int          NBITS         = 16,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic       clk_in,
    input  logic       RST_in,
    input  logic       level_in,
    output logic       sig_out,
    output logic       busy_out,
    output logic       settled_out,
    output logic [7:0] bounce_cnt_out
);
    typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE} state_t;
    state_t           state, state_n;
    logic [15:0]      lfsr, lfsr_n;
    logic [NBITS-1:0] ivl, ivl_n, settle, settle_n, load;
    logic             target, target_n, sig_n, settled_n;
    logic [7:0]       cnt_n;
    if (NBOUNCES % 2 != 0 || NBOUNCES < 2 || NBOUNCES > 255) begin : g_bad_nbounces
        $error("bounce_gen: NBOUNCES must be even and within 2..255");
    end
    if (BOUNCE_CYCLES < 2 || (BOUNCE_CYCLES & (BOUNCE_CYCLES - 1)) != 0) begin : g_bad_bounce
        $error("bounce_gen: BOUNCE_CYCLES must be a power of 2, >= 2");
    end
    if (LFSR_SEED == 16'h0) begin : g_bad_seed
        $error("bounce_gen: LFSR_SEED must be nonzero");
    end
    // Galois form of x^16+x^14+x^13+x^11+1, shifting right
    assign lfsr_n   = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    assign load     = NBITS'(lfsr & 16'(BOUNCE_CYCLES - 1)) + NBITS'(1);
    assign busy_out = state != IDLE;
    always_comb begin
        state_n   = state;
        target_n  = target;
        sig_n     = sig_out;
        cnt_n     = bounce_cnt_out;
        ivl_n     = ivl;
        settle_n  = settle;
        settled_n = 1'b0;
        case (state)
            IDLE: if (level_in != target) begin
                target_n = level_in;
                sig_n    = level_in;
                cnt_n    = 8'd0;
                ivl_n    = load;
                state_n  = BOUNCE;
            end
            BOUNCE: if (ivl == NBITS'(1)) begin
                sig_n = ~sig_out;
                cnt_n = bounce_cnt_out + 8'd1;
                ivl_n = load;
                // even toggle count leaves sig_out back on target here
                if (bounce_cnt_out == 8'(NBOUNCES - 1)) begin
                    state_n  = SETTLE;
                    settle_n = NBITS'(SETTLE_CYCLES);
                end
            end else ivl_n = ivl - NBITS'(1);
            SETTLE: if (settle == NBITS'(1)) begin
                settled_n = 1'b1;
                state_n   = IDLE;
            end else settle_n = settle - NBITS'(1);
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk_in or posedge RST_in) begin
        if (RST_in) begin
            state          <= IDLE;
            lfsr           <= LFSR_SEED;
            ivl            <= '0;
            settle         <= '0;
            target         <= 1'b0;
            sig_out        <= 1'b0;
            settled_out    <= 1'b0;
            bounce_cnt_out <= 8'd0;
        end else begin
            state          <= state_n;
            lfsr           <= lfsr_n;
            ivl            <= ivl_n;
            settle         <= settle_n;
            target         <= target_n;
            sig_out        <= sig_n;
            settled_out    <= settled_n;
            bounce_cnt_out <= cnt_n;
        end
    end
endmodule

// File: tb/tb_bounce_gen.sv
// tb_bounce_gen: scoreboard bench for bounce_gen with short bounce/settle parameters.
module tb_bounce_gen;
    localparam int BC = 4, NB = 4, SC = 8;
    localparam logic [15:0] SEED = 16'hACE1;
    typedef struct packed {logic target; logic b2b;} exp_t;
    logic clk_in = 1'b0, RST_in, level_in;
    logic sig_out, busy_out, settled_out;
    logic [7:0] bounce_cnt_out;
    int npass = 0, ntot = 0;
    exp_t q[$];
    exp_t cur;
    logic [15:0] m_lfsr, edge_lfsr;
    int cyc, start_cyc, last_cyc, settle_cyc, exp_gap, toggles, n_start = 0, n_done = 0, epoch;
    logic prev_sig, in_trans, fresh, fresh_pending;
    logic [31:0] rec, recs [2];

    bounce_gen #(.BOUNCE_CYCLES(BC), .NBOUNCES(NB), .SETTLE_CYCLES(SC), .NBITS(16), .LFSR_SEED(SEED)) dut (
        .clk_in(clk_in), .RST_in(RST_in), .level_in(level_in), .sig_out(sig_out),
        .busy_out(busy_out), .settled_out(settled_out), .bounce_cnt_out(bounce_cnt_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference LFSR: value seen by the DUT at each edge, plus cycles since reset
    always @(posedge clk_in) begin
        if (RST_in) begin
            m_lfsr = SEED;
            cyc = 0;
        end else begin
            edge_lfsr = m_lfsr;
            m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
            cyc++;
        end
    end

    always @(negedge clk_in) begin
        if (RST_in) begin
            prev_sig = 1'b0;
            in_trans = 1'b0;
        end else begin
            if (settled_out) begin
                chk("settled_in_trans", in_trans, 1);
                chk("toggle_count", toggles, NB);
                chk("settle_len", cyc - last_cyc, SC);
                chk("final_level", sig_out, cur.target);
                chk("final_cnt", bounce_cnt_out, NB);
                chk("busy_at_settle", busy_out, 0);
                chk("total_len_le25", (cyc - start_cyc) <= 1 + NB * BC + SC, 1);
                if (fresh) recs[epoch] = rec;
                in_trans = 1'b0;
                settle_cyc = cyc;
                n_done++;
            end
            if (sig_out != prev_sig) begin
                if (!in_trans) begin
                    chk("start_expected", q.size() != 0, 1);
                    cur = (q.size() != 0) ? q.pop_front() : '{target: sig_out, b2b: 1'b0};
                    chk("start_level", sig_out, cur.target);
                    chk("start_cnt", bounce_cnt_out, 0);
                    chk("start_busy", busy_out, 1);
                    if (cur.b2b) chk("b2b_start", cyc, settle_cyc + 1);
                    in_trans = 1'b1;
                    toggles = 0;
                    start_cyc = cyc;
                    last_cyc = cyc;
                    exp_gap = int'(edge_lfsr & 16'(BC - 1)) + 1;
                    fresh = fresh_pending;
                    fresh_pending = 1'b0;
                    rec = 0;
                    n_start++;
                end else begin
                    toggles++;
                    chk("gap", cyc - last_cyc, exp_gap);
                    chk("bounce_cnt", bounce_cnt_out, toggles);
                    chk("busy_bounce", busy_out, 1);
                    rec = {rec[23:0], 8'(cyc - last_cyc)};
                    last_cyc = cyc;
                    exp_gap = int'(edge_lfsr & 16'(BC - 1)) + 1;
                end
            end
            prev_sig = sig_out;
        end
    end

    task automatic wait_done(input int n);
        for (int i = 0; i < 200 && n_done < n; i++) @(negedge clk_in);
        chk("done_timeout", n_done >= n, 1);
    endtask

    task automatic wait_start(input int n);
        for (int i = 0; i < 200 && n_start < n; i++) @(negedge clk_in);
        chk("start_timeout", n_start >= n, 1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_sig"}, sig_out, 0);
        chk({tag, "_busy"}, busy_out, 0);
        chk({tag, "_settled"}, settled_out, 0);
        chk({tag, "_cnt"}, bounce_cnt_out, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_in = 1'b1;
        level_in = 1'b1;
        fresh_pending = 1'b1;
        epoch = 0;
        recs[0] = 0;
        recs[1] = 0;
        repeat (3) @(negedge clk_in);
        chk_reset("reset");
        q.push_back('{target: 1'b1, b2b: 1'b0});
        RST_in = 1'b0;
        @(negedge clk_in);
        chk("first_edge_sig", sig_out, 1);
        chk("first_edge_busy", busy_out, 1);
        @(negedge clk_in);
        level_in = 1'b0;
        q.push_back('{target: 1'b0, b2b: 1'b1});
        wait_done(1);
        wait_start(2);
        repeat (2) @(negedge clk_in);
        level_in = 1'b1;
        @(negedge clk_in);
        level_in = 1'b0;
        wait_done(2);
        repeat (20) @(negedge clk_in);
        chk("glitch_idle_busy", busy_out, 0);
        chk("glitch_idle_sig", sig_out, 0);
        chk("glitch_no_start", n_start, 2);
        level_in = 1'b1;
        q.push_back('{target: 1'b1, b2b: 1'b0});
        wait_start(3);
        @(negedge clk_in);
        @(posedge clk_in);
        #2 RST_in = 1'b1;
        #1 chk_reset("mid_reset");
        epoch = 1;
        fresh_pending = 1'b1;
        q.push_back('{target: 1'b1, b2b: 1'b0});
        repeat (2) @(negedge clk_in);
        RST_in = 1'b0;
        @(negedge clk_in);
        chk("rerun_first_sig", sig_out, 1);
        wait_done(3);
        chk("rec_nonzero", recs[0] != 0, 1);
        chk("determinism", recs[1], recs[0]);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in);
            level_in = ~level_in;
            q.push_back('{target: level_in, b2b: 1'b0});
            wait_done(4 + i);
        end
        repeat (10) @(negedge clk_in);
        chk("end_busy", busy_out, 0);
        chk("end_cnt_hold", bounce_cnt_out, NB);
        chk("end_sig", sig_out, level_in);
        chk("end_queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
